noc_local_inject_arb: RTL and testbench

Packet-atomic arbiter that shares one router LOCAL injection port among several on-tile requesters (core load/store unit, DMA, sync unit). It sits between those requesters and the `node_in_*_local` port of one mesh node. It grants one requester at a time in round-robin order and holds the grant until that requester's `last` flit is accepted, so wormhole packets are never interleaved. It steers valid onto the virtual channel requested at grant time and flags malformed packets.

---
 rtl/noc_local_inject_arb_if.sv | 27 ++
 rtl/noc_local_inject_arb.sv | 149 ++++++++++++++
 tb/tb_noc_local_inject_arb.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/noc_local_inject_arb_if.sv
// Bundle of the requester-side and router-side flit handshakes around the
// local-injection arbiter. The arbiter takes the master view; the tile side takes the slave view.
interface noc_local_inject_arb_if #(
   parameter int FLIT_WIDTH = 32,
   parameter int CHANNELS   = 2,
   parameter int REQS       = 3
);
   logic [REQS-1:0][FLIT_WIDTH-1:0] req_flit;
   logic [REQS-1:0]                 req_last;
   logic [REQS-1:0]                 req_valid;
   logic [REQS-1:0][CHANNELS-1:0]   req_vc;
   logic [REQS-1:0]                 req_ready;
   logic [FLIT_WIDTH-1:0]           out_flit;
   logic                            out_last;
   logic [CHANNELS-1:0]             out_valid;
   logic [CHANNELS-1:0]             out_ready;

   modport master (
      input  req_flit, req_last, req_valid, req_vc, out_ready,
      output req_ready, out_flit, out_last, out_valid
   );

   modport slave (
      output req_flit, req_last, req_valid, req_vc, out_ready,
      input  req_ready, out_flit, out_last, out_valid
   );
endinterface

// File: rtl/noc_local_inject_arb.sv
// Packet-atomic round-robin arbiter feeding one router LOCAL injection port.
// Define NOC_INJ_PRIO_EN to give requester 0 absolute priority at each arbitration.
module noc_local_inject_arb #(
   parameter int FLIT_WIDTH  = 32,
   parameter int CHANNELS    = 2,
   parameter int REQS        = 3,
   parameter int MAX_PKT_LEN = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   noc_local_inject_arb_if.master    bus,
   output logic                      busy,
   output logic [$clog2(REQS)-1:0]   grant_id,
   output logic                      err_vc,
   output logic                      err_len,
   input  logic                      err_clr
);
   localparam int GW = $clog2(REQS);
   localparam int CW = $clog2(MAX_PKT_LEN + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(MAX_PKT_LEN - 1);
`ifdef NOC_INJ_PRIO_EN
   localparam bit PRIO = 1'b1;
`else
   localparam bit PRIO = 1'b0;
`endif

   typedef enum logic {IDLE, XFER} state_e;

   state_e              state_q, state_d;
   logic [GW-1:0]       rr_ptr_q, rr_ptr_d;
   logic [GW-1:0]       grant_id_q, grant_id_d;
   logic [CHANNELS-1:0] vc_q, vc_d;
   logic [CW-1:0]       flit_cnt_q, flit_cnt_d;
   logic                err_vc_q, err_vc_d;
   logic                err_len_q, err_len_d;

   logic [REQS-1:0]     elig, bad_vc;
   logic                pick_vld;
   logic [GW-1:0]       pick;
   logic                g_ready, xfer;

   function automatic logic is_onehot(input logic [CHANNELS-1:0] v);
      return (v != '0) && ((v & (v - CHANNELS'(1))) == '0);
   endfunction

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
      return (&c) ? c : c + CW'(1);
   endfunction

   function automatic logic [GW-1:0] next_idx(input logic [GW-1:0] g);
      return (g == GW'(REQS - 1)) ? '0 : g + GW'(1);
   endfunction

   always_comb begin
      elig   = '0;
      bad_vc = '0;
      for (int i = 0; i < REQS; i++) begin
         elig[i]   = bus.req_valid[i] & is_onehot(bus.req_vc[i]);
         bad_vc[i] = bus.req_valid[i] & ~is_onehot(bus.req_vc[i]);
      end
   end

   // Search from rr_ptr; in priority mode requester 0 pre-empts the search and is skipped by it.
   always_comb begin
      int idx;
      pick_vld = 1'b0;
      pick     = '0;
      idx      = 0;
      if (PRIO && elig[0]) begin
         pick_vld = 1'b1;
      end else begin
         for (int k = 0; k < REQS; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= REQS) idx = idx - REQS;
            if (!pick_vld && elig[idx] && !(PRIO && idx == 0)) begin
               pick_vld = 1'b1;
               pick     = GW'(idx);
            end
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      rr_ptr_d      = rr_ptr_q;
      grant_id_d    = grant_id_q;
      vc_d          = vc_q;
      flit_cnt_d    = flit_cnt_q;
      err_vc_d      = (|bad_vc) | (err_vc_q & ~err_clr);
      err_len_d     = err_len_q & ~err_clr;
      bus.out_flit  = '0;
      bus.out_last  = 1'b0;
      bus.out_valid = '0;
      bus.req_ready = '0;
      g_ready       = |(bus.out_ready & vc_q);
      xfer          = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_vld) begin
               state_d    = XFER;
               grant_id_d = pick;
               vc_d       = bus.req_vc[pick];
               flit_cnt_d = '0;
            end
         end
         XFER: begin
            bus.out_flit  = bus.req_flit[grant_id_q];
            bus.out_last  = bus.req_last[grant_id_q];
            bus.out_valid = vc_q & {CHANNELS{bus.req_valid[grant_id_q]}};
            bus.req_ready[grant_id_q] = g_ready;
            xfer = bus.req_valid[grant_id_q] & g_ready;
            if (xfer) begin
               flit_cnt_d = sat_inc(flit_cnt_q);
               if (!bus.req_last[grant_id_q] && flit_cnt_q == CNT_LAST) err_len_d = 1'b1;
               if (bus.req_last[grant_id_q]) begin
                  state_d = IDLE;
                  if (!PRIO || grant_id_q != '0) rr_ptr_d = next_idx(grant_id_q);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         grant_id_q <= '0;
         vc_q       <= '0;
         flit_cnt_q <= '0;
         err_vc_q   <= 1'b0;
         err_len_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         grant_id_q <= grant_id_d;
         vc_q       <= vc_d;
         flit_cnt_q <= flit_cnt_d;
         err_vc_q   <= err_vc_d;
         err_len_q  <= err_len_d;
      end
   end

   assign busy     = (state_q == XFER);
   assign grant_id = grant_id_q;
   assign err_vc   = err_vc_q;
   assign err_len  = err_len_q;
endmodule

// File: tb/tb_noc_local_inject_arb.sv
// Directed and randomized bench for noc_local_inject_arb against a packet-level reference model.
module tb_noc_local_inject_arb;
   localparam int FW = 32, CH = 2, NR = 3, MAXL = 16;
   localparam int CNT_SAT = (1 << $clog2(MAXL + 1)) - 1;

   logic       clk = 1'b0, rst_n = 1'b0, err_clr = 1'b0;
   logic       busy, err_vc, err_len;
   logic [1:0] grant_id;

   noc_local_inject_arb_if #(.FLIT_WIDTH(FW), .CHANNELS(CH), .REQS(NR)) bus ();

   noc_local_inject_arb #(.FLIT_WIDTH(FW), .CHANNELS(CH), .REQS(NR), .MAX_PKT_LEN(MAXL)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .grant_id(grant_id),
      .err_vc(err_vc), .err_len(err_len), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int compared = 0, mismatched = 0;

   // reference model: owner = -1 when no packet is granted
   int         m_owner = -1, m_rr = 0, m_cnt = 0, m_gid = 0;
   logic [1:0] m_vc = 2'b00;
   bit         m_evc = 1'b0, m_elen = 1'b0;

   // requester traffic sources
   int         s_len[NR], s_pos[NR];
   logic [1:0] s_vc[NR];
   logic [31:0] s_dat[NR];
   bit [NR-1:0] s_on = '0, s_rep = '0;
   bit         s_gaps = 1'b0, s_rnd = 1'b0;

   int  dut_acc = 0, acc_ch0 = 0, acc_ch1 = 0, rise_at = -1;
   bit  busy_prev = 1'b0, elen_prev = 1'b0;
   int  dlog[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < NR; i++) begin
         bus.req_valid[i] = s_on[i] && (!s_gaps || $urandom_range(0, 3) != 0);
         bus.req_flit[i]  = s_dat[i];
         bus.req_last[i]  = (s_pos[i] == s_len[i] - 1);
         bus.req_vc[i]    = s_vc[i];
      end
   endtask

   task automatic model_update(input bit mx);
      bit bad, last;
      int best, bestd, d;
      if (!rst_n) begin
         m_owner = -1; m_rr = 0; m_gid = 0; m_vc = 2'b00; m_cnt = 0; m_evc = 0; m_elen = 0;
         return;
      end
      bad = 0;
      for (int i = 0; i < NR; i++)
         if (bus.req_valid[i] && !$onehot(bus.req_vc[i])) bad = 1;
      m_evc  = bad | (m_evc & !err_clr);
      m_elen = m_elen & !err_clr;
      if (m_owner < 0) begin
         best = -1; bestd = NR + 1;
         for (int i = 0; i < NR; i++) begin
            if (bus.req_valid[i] && $onehot(bus.req_vc[i])) begin
               d = (i - m_rr + NR) % NR;
`ifdef NOC_INJ_PRIO_EN
               if (i == 0) d = -1;
`endif
               if (d < bestd) begin bestd = d; best = i; end
            end
         end
         if (best >= 0) begin
            m_owner = best; m_gid = best; m_vc = bus.req_vc[best]; m_cnt = 0;
         end
      end else if (mx) begin
         last = bus.req_last[m_owner];
         if (!last && m_cnt == MAXL - 1) m_elen = 1;
         if (m_cnt < CNT_SAT) m_cnt++;
         if (last) begin
`ifdef NOC_INJ_PRIO_EN
            if (m_owner != 0) m_rr = (m_owner + 1) % NR;
`else
            m_rr = (m_owner + 1) % NR;
`endif
            m_owner = -1;
         end
      end
   endtask

   task automatic src_advance(input int g);
      if (g < 0) return;
      if (s_pos[g] == s_len[g] - 1) begin
         s_pos[g] = 0;
         if (!s_rep[g]) s_on[g] = 1'b0;
         if (s_rnd) begin
            s_len[g] = int'($urandom_range(1, 18));
            s_vc[g]  = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
         end
      end else begin
         s_pos[g]++;
      end
      s_dat[g] = $urandom();
   endtask

   task automatic step();
      logic [1:0]  e_ov;
      logic [31:0] e_of;
      logic        e_ol;
      logic [2:0]  e_rr;
      bit          mx;
      int          gx;
      drive();
      #2;
      e_ov = 2'b00; e_of = '0; e_ol = 1'b0; e_rr = 3'b000; mx = 0; gx = -1;
      if (m_owner >= 0) begin
         e_of = bus.req_flit[m_owner];
         e_ol = bus.req_last[m_owner];
         e_ov = bus.req_valid[m_owner] ? m_vc : 2'b00;
         e_rr[m_owner] = ((bus.out_ready & m_vc) != 2'b00);
         mx = bus.req_valid[m_owner] && e_rr[m_owner];
         if (mx) gx = m_owner;
      end
      chk("out_valid", 64'(bus.out_valid), 64'(e_ov));
      chk("out_flit",  64'(bus.out_flit),  64'(e_of));
      chk("out_last",  64'(bus.out_last),  64'(e_ol));
      chk("req_ready", 64'(bus.req_ready), 64'(e_rr));
      chk("busy",      64'(busy),          64'(m_owner >= 0));
      chk("grant_id",  64'(grant_id),      64'(m_gid));
      chk("err_vc",    64'(err_vc),        64'(m_evc));
      chk("err_len",   64'(err_len),       64'(m_elen));
      if (|(bus.out_valid & bus.out_ready)) dut_acc++;
      if (bus.out_valid[0] && bus.out_ready[0]) acc_ch0++;
      if (bus.out_valid[1] && bus.out_ready[1]) acc_ch1++;
      @(posedge clk);
      model_update(mx);
      if (rst_n) src_advance(gx);
      #1;
      if (busy && !busy_prev) dlog.push_back(int'(grant_id));
      if (err_len && !elen_prev) rise_at = dut_acc;
      busy_prev = busy;
      elen_prev = err_len;
   endtask

   task automatic drain(input bit [NR-1:0] mask, input int budget);
      int n;
      n = 0;
      while ((m_owner >= 0 || (s_on & mask) != '0) && n < budget) begin
         step();
         n++;
      end
      chk("drain_done", 64'(n < budget), 64'(1));
   endtask

   task automatic clear_counts();
      dut_acc = 0; acc_ch0 = 0; acc_ch1 = 0; rise_at = -1;
      dlog.delete();
   endtask

   initial begin
      int exp_rr[4], exp_pr[4];
`ifdef NOC_INJ_PRIO_EN
      exp_rr = '{0, 0, 0, 0};
      exp_pr = '{0, 0, 0, 0};
`else
      exp_rr = '{0, 1, 2, 0};
      exp_pr = '{0, 1, 0, 1};
`endif
      for (int i = 0; i < NR; i++) begin
         s_len[i] = 3; s_pos[i] = 0; s_vc[i] = 2'b01; s_dat[i] = $urandom();
      end
      bus.out_ready = 2'b11;
      s_on = '1; s_rep = '1;
      drive();

      // reset with all requesters valid
      rst_n = 1'b0;
      @(posedge clk); #1;
      step();
      step();
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_req_ready", 64'(bus.req_ready), 64'(0));

      // round robin across three continuous 3-flit streams
      rst_n = 1'b1;
      clear_counts();
      for (int k = 0; k < 20; k++) step();
      chk("rr_log_len", 64'(dlog.size() >= 4), 64'(1));
      for (int k = 0; k < 4; k++)
         if (k < dlog.size()) chk("rr_grant", 64'(dlog[k]), 64'(exp_rr[k]));
      s_rep = '0;
      drain('1, 100);

      // VC steering under backpressure, with a mid-packet req_vc flip
      clear_counts();
      s_len[1] = 4; s_pos[1] = 0; s_vc[1] = 2'b10; s_on[1] = 1'b1;
      bus.out_ready = 2'b01;
      for (int k = 0; k < 5; k++) step();
      chk("stall_ready", 64'(bus.req_ready[1]), 64'(0));
      bus.out_ready = 2'b11;
      step();
      s_vc[1] = 2'b01;
      drain(3'b010, 50);
      chk("vc1_flits", 64'(acc_ch1), 64'(4));
      chk("vc0_flits", 64'(acc_ch0), 64'(0));

      // over-length packet
      clear_counts();
      s_len[0] = 17; s_pos[0] = 0; s_vc[0] = 2'b01; s_on[0] = 1'b1;
      drain(3'b001, 60);
      chk("len_flits", 64'(dut_acc), 64'(17));
      chk("len_rise_at", 64'(rise_at), 64'(16));
      chk("len_sticky", 64'(err_len), 64'(1));
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      chk("len_clr", 64'(err_len), 64'(0));

      // multi-hot VC on requester 2 while requester 0 sends normally
      clear_counts();
      s_len[2] = 2; s_pos[2] = 0; s_vc[2] = 2'b11; s_on[2] = 1'b1; s_rep[2] = 1'b1;
      s_len[0] = 3; s_pos[0] = 0; s_vc[0] = 2'b01; s_on[0] = 1'b1;
      drain(3'b001, 50);
      chk("vc_err_set", 64'(err_vc), 64'(1));
      chk("vc_err_req0_flits", 64'(dut_acc), 64'(3));
      begin
         int n2;
         n2 = 0;
         foreach (dlog[k]) if (dlog[k] == 2) n2++;
         chk("vc_err_req2_grants", 64'(n2), 64'(0));
      end
      s_on[2] = 1'b0; s_rep[2] = 1'b0;
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      chk("vc_err_clr", 64'(err_vc), 64'(0));

      // two continuous contenders from a fresh reset
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      clear_counts();
      for (int i = 0; i < 2; i++) begin
         s_len[i] = 2; s_pos[i] = 0; s_vc[i] = 2'b01; s_on[i] = 1'b1; s_rep[i] = 1'b1;
      end
      for (int k = 0; k < 14; k++) step();
      chk("pr_log_len", 64'(dlog.size() >= 4), 64'(1));
      for (int k = 0; k < 4; k++)
         if (k < dlog.size()) chk("pr_grant", 64'(dlog[k]), 64'(exp_pr[k]));

      // randomized traffic with gaps, backpressure, error clears and a mid-packet reset
      s_gaps = 1'b1; s_rnd = 1'b1;
      for (int i = 0; i < NR; i++) begin
         s_on[i] = 1'b1; s_rep[i] = 1'b1; s_pos[i] = 0;
         s_len[i] = int'($urandom_range(1, 18));
         s_vc[i] = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      end
      for (int k = 0; k < 400; k++) begin
         bus.out_ready = 2'($urandom_range(0, 3));
         err_clr = ($urandom_range(0, 15) == 0);
         rst_n = (k != 200);
         step();
      end
      rst_n = 1'b1;
      err_clr = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
